gram_spi_tx: RTL and testbench

- Host-side SPI master that streams one full graphic frame from a byte-wide synchronous memory into the display controller's slave SPI port.
- Drives the SCLK/MOSI/SCS wires that the FPGA's slave SPI receiver samples.
- Used in the host bridge and as the stimulus driver for frame-load testing.
- Protocol: SPI mode 0 (SCLK idles low, receiver samples on SCLK rising edge), LSB-first within each byte, SCS active-low, bytes sent back-to-back with continuous SCLK.

---
 rtl/gram_spi_tx.sv | 189 ++++++++++++++++++
 tb/tb_gram_spi_tx.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/gram_spi_tx.sv
// gram_spi_tx: SPI mode-0 master that streams one frame from a byte memory.
// LSB-first, CS active low, gapless bytes via a one-byte prefetch.
module gram_spi_tx #(
  parameter int FRAME_BYTES = 3003,
  parameter int ADDR_W      = 12,
  parameter int CLK_DIV     = 2,
  parameter int CS_SETUP    = 2,
  parameter int CS_IDLE     = 4
) (
  input  logic              CLK,
  input  logic              RSTN,
  input  logic              START,
  output logic              BUSY,
  output logic              DONE,
  output logic              RD_EN,
  output logic [ADDR_W-1:0] RD_ADDR,
  input  logic [7:0]        RD_DATA,
  output logic              SCLK,
  output logic              MOSI,
  output logic              SCS
);

  localparam int M1   = (CLK_DIV > CS_SETUP) ? CLK_DIV : CS_SETUP;
  localparam int CMAX = (M1 > CS_IDLE) ? M1 : CS_IDLE;
  localparam int CW   = $clog2(CMAX + 1);

  localparam logic [ADDR_W-1:0] LAST_B = ADDR_W'(FRAME_BYTES - 1);
  localparam logic [CW-1:0]     DIV_M  = CW'(CLK_DIV - 1);
  localparam logic [CW-1:0]     SET_M  = CW'(CS_SETUP - 1);
  localparam logic [CW-1:0]     GAP_M  = CW'(CS_IDLE - 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_SETUP,
    S_SHIFT,
    S_LAST,
    S_GAP
  } state_t;

  state_t            state, state_d;
  logic [CW-1:0]     cnt, cnt_d;
  logic [2:0]        bit_idx, bit_d;
  logic [ADDR_W-1:0] byte_cnt, byte_d;
  logic [7:0]        sh, sh_d;
  logic [7:0]        hold, hold_d;
  logic [7:0]        src;
  logic              rd_q;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              scs_q, scs_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;

  assign BUSY    = busy_q;
  assign DONE    = done_q;
  assign RD_EN   = rd_en_q;
  assign RD_ADDR = rd_addr_q;
  assign SCLK    = sclk_q;
  assign MOSI    = mosi_q;
  assign SCS     = scs_q;

  // Memory data arrives the cycle after the strobe; CS_SETUP must be >= 2
  assign src = rd_q ? RD_DATA : sh;

  always_comb begin
    state_d   = state;
    cnt_d     = cnt;
    bit_d     = bit_idx;
    byte_d    = byte_cnt;
    sh_d      = sh;
    hold_d    = hold;
    sclk_d    = sclk_q;
    mosi_d    = mosi_q;
    scs_d     = scs_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    unique case (state)
      S_IDLE: begin
        if (START) begin
          state_d   = S_SETUP;
          cnt_d     = '0;
          bit_d     = '0;
          byte_d    = '0;
          scs_d     = 1'b0;
          busy_d    = 1'b1;
          rd_en_d   = 1'b1;
          rd_addr_d = '0;
        end
      end
      S_SETUP: begin
        sh_d = src;
        if (cnt == SET_M) begin
          state_d = S_SHIFT;
          cnt_d   = '0;
          mosi_d  = src[0];
          if (LAST_B != '0) begin
            rd_en_d   = 1'b1;
            rd_addr_d = ADDR_W'(1);
          end
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      S_SHIFT: begin
        if (rd_q) hold_d = RD_DATA;
        if (cnt != DIV_M) begin
          cnt_d = cnt + CW'(1);
        end else begin
          cnt_d  = '0;
          sclk_d = ~sclk_q;
          if (sclk_q) begin
            if (bit_idx != 3'd7) begin
              bit_d  = bit_idx + 3'd1;
              sh_d   = sh >> 1;
              mosi_d = sh[1];
            end else if (byte_cnt == LAST_B) begin
              state_d = S_LAST;
            end else begin
              // Byte boundary: prefetched byte takes over, next fetch issued
              bit_d  = '0;
              byte_d = byte_cnt + ADDR_W'(1);
              sh_d   = hold;
              mosi_d = hold[0];
              if (byte_cnt + ADDR_W'(1) != LAST_B) begin
                rd_en_d   = 1'b1;
                rd_addr_d = byte_cnt + ADDR_W'(2);
              end
            end
          end
        end
      end
      S_LAST: begin
        state_d = S_GAP;
        cnt_d   = '0;
        scs_d   = 1'b1;
        mosi_d  = 1'b0;
      end
      S_GAP: begin
        if (cnt == GAP_M) begin
          state_d = S_IDLE;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          cnt_d = cnt + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge CLK or negedge RSTN) begin
    if (!RSTN) begin
      state     <= S_IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      byte_cnt  <= '0;
      sh        <= '0;
      hold      <= '0;
      rd_q      <= 1'b0;
      sclk_q    <= 1'b0;
      mosi_q    <= 1'b0;
      scs_q     <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
    end else begin
      state     <= state_d;
      cnt       <= cnt_d;
      bit_idx   <= bit_d;
      byte_cnt  <= byte_d;
      sh        <= sh_d;
      hold      <= hold_d;
      rd_q      <= rd_en_q;
      sclk_q    <= sclk_d;
      mosi_q    <= mosi_d;
      scs_q     <= scs_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
    end
  end

endmodule

// File: tb/tb_gram_spi_tx.sv
// Bench for gram_spi_tx: cycle-offset model of a frame plus SPI bit monitor.
// Directed frames: pulse start, busy-time starts, held start, mid-frame reset.
module tb_gram_spi_tx;

  localparam int FB  = 4;
  localparam int CD  = 2;
  localparam int CSS = 2;
  localparam int CSI = 4;
  localparam int SH0 = 1 + CSS;
  localparam int NSH = FB * 16 * CD;
  localparam int L   = 1 + CSS + NSH + 1 + CSI;

  logic        clk = 1'b0;
  logic        RSTN = 1'b0;
  logic        START = 1'b0;
  logic        BUSY, DONE, RD_EN, SCLK, MOSI, SCS;
  logic [11:0] RD_ADDR;
  logic [7:0]  rd_data = 8'h00;
  logic [7:0]  mem [0:FB-1];

  int n_cmp = 0;
  int n_err = 0;
  int cyc = 0;
  int k = 0;

  int rises = 0;
  int rd_cnt = 0;
  int last_rise = 0;
  logic [31:0] got = '0;

  gram_spi_tx #(
    .FRAME_BYTES(FB),
    .ADDR_W(12),
    .CLK_DIV(CD),
    .CS_SETUP(CSS),
    .CS_IDLE(CSI)
  ) dut (
    .CLK(clk),
    .RSTN(RSTN),
    .START(START),
    .BUSY(BUSY),
    .DONE(DONE),
    .RD_EN(RD_EN),
    .RD_ADDR(RD_ADDR),
    .RD_DATA(rd_data),
    .SCLK(SCLK),
    .MOSI(MOSI),
    .SCS(SCS)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(posedge clk)
    rd_data <= (RD_EN && RD_ADDR < 12'(FB)) ? mem[RD_ADDR[1:0]] : 8'h5A;

  // Model: k = cycles since the accepting edge, 0 when idle
  always @(posedge clk or negedge RSTN) begin
    if (!RSTN) k <= 0;
    else if (k == 0 || k == L) k <= START ? 1 : 0;
    else k <= k + 1;
  end

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  // Per-cycle comparison against the model
  initial begin
    logic e_scs, e_sclk, e_mosi, e_mv, e_busy, e_done, win;
    logic [7:0] b;
    int s, bp;
    forever begin
      @(negedge clk);
      if (RSTN) begin
        e_scs = 1'b1; e_sclk = 1'b0; e_mosi = 1'b0; e_mv = 1'b1;
        e_busy = 1'b0; e_done = 1'b0; win = 1'b0; bp = 0;
        if (k == L) begin
          e_done = 1'b1;
        end else if (k >= 1 && k < SH0) begin
          e_scs = 1'b0; e_busy = 1'b1; e_mv = 1'b0;
        end else if (k >= SH0 && k < SH0 + NSH) begin
          s = k - SH0;
          bp = s / (2 * CD);
          e_scs = 1'b0;
          e_busy = 1'b1;
          e_sclk = (s % (2 * CD)) >= CD;
          b = mem[bp / 8];
          e_mosi = b[bp % 8];
          win = (bp % 8 == 0) && (bp / 8 < FB - 1);
        end else if (k == SH0 + NSH) begin
          e_scs = 1'b0; e_busy = 1'b1; e_mv = 1'b0;
        end else if (k > SH0 + NSH) begin
          e_busy = 1'b1;
        end
        chk("SCS", 32'(SCS), 32'(e_scs));
        chk("SCLK", 32'(SCLK), 32'(e_sclk));
        chk("BUSY", 32'(BUSY), 32'(e_busy));
        chk("DONE", 32'(DONE), 32'(e_done));
        if (e_mv) chk("MOSI", 32'(MOSI), 32'(e_mosi));
        if (k == 1) begin
          chk("RD_EN_first", 32'(RD_EN), 32'd1);
          chk("RD_ADDR_first", 32'(RD_ADDR), 32'd0);
        end else if (RD_EN) begin
          if (win) chk("RD_ADDR_pref", 32'(RD_ADDR), 32'(bp / 8 + 1));
          else chk("RD_EN_stray", 32'(RD_EN), 32'd0);
        end
      end
    end
  end

  // SPI monitor: bits on rising SCLK, period, MOSI stability, read count
  initial begin
    logic p_sclk, p_scs, p_mosi;
    p_sclk = 1'b0; p_scs = 1'b1; p_mosi = 1'b0;
    forever begin
      @(negedge clk);
      if (!RSTN) begin
        p_sclk = 1'b0; p_scs = 1'b1; p_mosi = 1'b0;
      end else begin
        if (p_scs && !SCS) begin
          rises = 0; got = '0; rd_cnt = 0;
        end
        if (RD_EN) rd_cnt++;
        if (SCLK && !p_sclk) begin
          if (rises > 0) chk("sclk_period", cyc - last_rise, 2 * CD);
          if (rises < 32) got[rises] = MOSI;
          rises++;
          last_rise = cyc;
        end else if (SCLK && p_sclk) begin
          chk("MOSI_stable", 32'(MOSI), 32'(p_mosi));
        end
        p_sclk = SCLK; p_scs = SCS; p_mosi = MOSI;
      end
    end
  end

  task automatic wait_done(output int c);
    int n;
    c = -1;
    n = 0;
    while (n < 400 && c < 0) begin
      @(negedge clk);
      n++;
      if (DONE) c = cyc;
    end
    if (c < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL done_timeout: got none expected DONE within 400");
    end
  endtask

  task automatic frame_checks(input string tag, input int len,
                              input logic [31:0] stream);
    chk({tag, "_len"}, len, 32'd136);
    chk({tag, "_rises"}, rises, 32'd32);
    chk({tag, "_stream"}, got, stream);
    chk({tag, "_rd_cnt"}, rd_cnt, 32'd4);
  endtask

  initial begin
    int c0, cd;
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h01; mem[3] = 8'hFF;
    repeat (3) @(negedge clk);
    chk("rst_SCS", 32'(SCS), 32'd1);
    chk("rst_SCLK", 32'(SCLK), 32'd0);
    chk("rst_MOSI", 32'(MOSI), 32'd0);
    chk("rst_BUSY", 32'(BUSY), 32'd0);
    chk("rst_DONE", 32'(DONE), 32'd0);
    chk("rst_RD_EN", 32'(RD_EN), 32'd0);
    chk("rst_RD_ADDR", 32'(RD_ADDR), 32'd0);
    RSTN = 1'b1;
    repeat (3) @(negedge clk);

    // Single START pulse
    START = 1'b1; c0 = cyc;
    @(negedge clk); START = 1'b0;
    wait_done(cd);
    frame_checks("f1", cd - c0, 32'hFF013CA5);
    @(negedge clk);
    chk("done_pulse", 32'(DONE), 32'd0);

    // Different image, START pulses while BUSY are ignored
    mem[0] = 8'h12; mem[1] = 8'h80; mem[2] = 8'hC3; mem[3] = 8'h7E;
    repeat (2) @(negedge clk);
    START = 1'b1; c0 = cyc;
    @(negedge clk); START = 1'b0;
    repeat (20) @(negedge clk);
    START = 1'b1;
    @(negedge clk); START = 1'b0;
    repeat (60) @(negedge clk);
    START = 1'b1;
    @(negedge clk); START = 1'b0;
    wait_done(cd);
    frame_checks("f2", cd - c0, 32'h7EC38012);
    repeat (10) @(negedge clk);
    chk("no_extra_frame", 32'(BUSY), 32'd0);

    // START held high: second frame begins right after DONE
    START = 1'b1; c0 = cyc;
    wait_done(cd);
    frame_checks("f3", cd - c0, 32'h7EC38012);
    c0 = cd;
    @(negedge clk);
    chk("b2b_SCS", 32'(SCS), 32'd0);
    chk("b2b_BUSY", 32'(BUSY), 32'd1);
    START = 1'b0;
    wait_done(cd);
    frame_checks("f4", cd - c0, 32'h7EC38012);

    // Reset during byte 2 bit 5 (SCLK high phase)
    mem[0] = 8'hA5; mem[1] = 8'h3C; mem[2] = 8'h01; mem[3] = 8'hFF;
    repeat (3) @(negedge clk);
    START = 1'b1;
    @(negedge clk); START = 1'b0;
    for (int i = 0; i < 200 && k != 89; i++) @(negedge clk);
    chk("pre_rst_SCS", 32'(SCS), 32'd0);
    chk("pre_rst_SCLK", 32'(SCLK), 32'd1);
    #2 RSTN = 1'b0;
    #1;
    chk("arst_SCS", 32'(SCS), 32'd1);
    chk("arst_SCLK", 32'(SCLK), 32'd0);
    chk("arst_BUSY", 32'(BUSY), 32'd0);
    repeat (2) @(negedge clk);
    RSTN = 1'b1;
    repeat (2) @(negedge clk);
    START = 1'b1; c0 = cyc;
    @(negedge clk); START = 1'b0;
    wait_done(cd);
    frame_checks("f5", cd - c0, 32'hFF013CA5);
    repeat (5) @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
